// File: rtl/alarm_sequencer.sv
// alarm_sequencer: keypad passcode engine, wrong-code lockout and the
// arm/disarm state machine (DISARMED, EXIT, ARMED, ENTRY, ALARM).
// Optional: define DURESS_EN to accept a duress code (last digit ^ 1) that
// disarms like the real code and latches a silent duress_alert until rst.
module alarm_sequencer #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0] PASSCODE       = 16'h0965,
  parameter logic [3:0]            CLEAR_KEY      = 4'hF,
  parameter int                    EXIT_DELAY     = 16,
  parameter int                    ENTRY_DELAY    = 16,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    LOCKOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       breach,
  output logic [2:0] state_o,
  output logic       is_enabled,
  output logic       led,
  output logic       alert_authorities,
  output logic       lockout,
  output logic       duress_alert
);

  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int LW   = $clog2(LOCKOUT_CYCLES + 1);
  localparam int DMAX = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int DW   = $clog2(DMAX + 1);
  // Only the first CODE_LEN-1 digits need storing; the last one is compared live.
  localparam int DGW  = (CODE_LEN > 1) ? 4 * (CODE_LEN - 1) : 4;

  typedef enum logic [2:0] {
    S_DIS  = 3'd0,
    S_EXIT = 3'd1,
    S_ARM  = 3'd2,
    S_ENT  = 3'd3,
    S_ALM  = 3'd4
  } state_t;

  state_t                state, nxt;
  logic [DW-1:0]         dtmr, nxt_dtmr;
  logic [DGW-1:0]        digits;
  logic [CW-1:0]         dig_cnt;
  logic [FW-1:0]         fail_cnt;
  logic [LW-1:0]         lock_tmr;
  logic [4*CODE_LEN-1:0] entry;
  logic                  key_ok, last, pass_hit, duress_hit, code_ok;

  // Full candidate entry: stored digits followed by the incoming key.
  generate
    if (CODE_LEN > 1) begin : g_multi
      assign entry = {digits, key_code};
    end else begin : g_single
      assign entry = key_code;
    end
  endgenerate

  // Decide whether this edge completes an entry and whether it matches.
  always_comb begin
    key_ok     = key_valid && !lockout && (key_code != CLEAR_KEY);
    last       = key_ok && (dig_cnt == CW'(CODE_LEN - 1));
    pass_hit   = last && (entry == PASSCODE);
`ifdef DURESS_EN
    duress_hit = last && (entry == (PASSCODE ^ (4*CODE_LEN)'(1)));
`else
    duress_hit = 1'b0;
`endif
    code_ok    = pass_hit || duress_hit;
  end

  // Entry engine: digit collection, fail counting and lockout timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits   <= '0;
      dig_cnt  <= '0;
      fail_cnt <= '0;
      lockout  <= 1'b0;
      lock_tmr <= '0;
    end else if (lockout) begin
      // Keys are dropped while locked; timer counts down to release.
      if (lock_tmr == LW'(1)) lockout <= 1'b0;
      lock_tmr <= lock_tmr - LW'(1);
    end else if (key_valid) begin
      if (key_code == CLEAR_KEY) begin
        dig_cnt <= '0;
      end else if (last) begin
        dig_cnt <= '0;
        if (code_ok) begin
          fail_cnt <= '0;
        end else if (fail_cnt == FW'(MAX_FAILS - 1)) begin
          fail_cnt <= '0;
          lockout  <= 1'b1;
          lock_tmr <= LW'(LOCKOUT_CYCLES);
        end else begin
          fail_cnt <= fail_cnt + FW'(1);
        end
      end else begin
        dig_cnt <= dig_cnt + CW'(1);
        digits  <= entry[DGW-1:0];
      end
    end
  end

  // Next state: code_ok takes priority over delay expiry and breach.
  always_comb begin
    nxt      = state;
    nxt_dtmr = dtmr;
    case (state)
      S_DIS: if (code_ok) begin
        nxt      = S_EXIT;
        nxt_dtmr = DW'(EXIT_DELAY - 1);
      end
      S_EXIT: begin
        if (code_ok)            nxt = S_DIS;
        else if (dtmr == '0)    nxt = S_ARM;
        else                    nxt_dtmr = dtmr - DW'(1);
      end
      S_ARM: begin
        if (code_ok) nxt = S_DIS;
        else if (breach) begin
          nxt      = S_ENT;
          nxt_dtmr = DW'(ENTRY_DELAY - 1);
        end
      end
      S_ENT: begin
        if (code_ok)            nxt = S_DIS;
        else if (dtmr == '0)    nxt = S_ALM;
        else                    nxt_dtmr = dtmr - DW'(1);
      end
      S_ALM:   if (code_ok) nxt = S_DIS;
      default: nxt = S_DIS;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_DIS;
      dtmr              <= '0;
      state_o           <= 3'd0;
      is_enabled        <= 1'b0;
      led               <= 1'b0;
      alert_authorities <= 1'b0;
    end else begin
      state             <= nxt;
      dtmr              <= nxt_dtmr;
      state_o           <= nxt;
      is_enabled        <= (nxt != S_DIS);
      led               <= (nxt != S_DIS);
      alert_authorities <= (nxt == S_ALM);
    end
  end

`ifdef DURESS_EN
  // Silent duress flag, sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             duress_alert <= 1'b0;
    else if (duress_hit) duress_alert <= 1'b1;
  end
`else
  assign duress_alert = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with hand-computed expectations.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       breach = 1'b0;
  logic [2:0] state_o;
  logic       is_enabled, led, alert_authorities, lockout, duress_alert;

  int n_chk = 0;
  int n_bad = 0;

  alarm_sequencer dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .breach(breach), .state_o(state_o), .is_enabled(is_enabled), .led(led),
    .alert_authorities(alert_authorities), .lockout(lockout),
    .duress_alert(duress_alert)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n edges, land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick(1);
    key_valid = 1'b0;
  endtask

  task automatic code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) key(c[i*4 +: 4]);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_en", is_enabled, 0);
    chk("rst_led", led, 0);
    chk("rst_alert", alert_authorities, 0);
    chk("rst_lock", lockout, 0);
    chk("rst_duress", duress_alert, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);

    // Arm: EXIT on 4th key, ARMED exactly 16 cycles later
    key(4'h0); key(4'h9); key(4'h6);
    chk("pre4_state", state_o, 0);
    key(4'h5);
    chk("exit_state", state_o, 1);
    chk("exit_led", led, 1);
    tick(15);
    chk("exit_hold", state_o, 1);
    tick(1);
    chk("armed_state", state_o, 2);
    chk("armed_en", is_enabled, 1);
    chk("armed_led", led, 1);

    // Breach pulse -> ENTRY 16 cycles -> ALARM
    breach = 1'b1; tick(1); breach = 1'b0;
    chk("entry_state", state_o, 3);
    tick(15);
    chk("entry_hold", state_o, 3);
    chk("entry_noalert", alert_authorities, 0);
    tick(1);
    chk("alarm_state", state_o, 4);
    chk("alarm_alert", alert_authorities, 1);
    code(16'h0965);
    chk("disarm_state", state_o, 0);
    chk("disarm_alert", alert_authorities, 0);
    chk("disarm_led", led, 0);
    chk("disarm_en", is_enabled, 0);

    // Three wrong entries -> lockout for 32 cycles
    code(16'h0000);
    code(16'h0000);
    chk("fail2_nolock", lockout, 0);
    code(16'h0000);
    chk("fail3_lock", lockout, 1);
    code(16'h0965);
    chk("locked_state", state_o, 0);
    tick(27);
    chk("lock_hold", lockout, 1);
    tick(1);
    chk("lock_drop", lockout, 0);
    code(16'h0965);
    chk("postlock_arm", state_o, 1);
    code(16'h0965);
    chk("exit_disarm", state_o, 0);

    // Partial entry cleared, then correct code arms; no failure counted
    key(4'h0); key(4'h9); key(4'hF);
    code(16'h0965);
    chk("clear_arm", state_o, 1);
    code(16'h0000);
    code(16'h0000);
    chk("clear_nolock", lockout, 0);
    chk("wrong_in_exit", state_o, 1);

    // Correct 4th digit on the edge the exit timer expires -> DISARMED
    tick(4);
    code(16'h0965);
    chk("race_exit", state_o, 0);

    // ARMED with breach and 4th correct digit on the same edge -> DISARMED
    code(16'h0965);
    tick(16);
    chk("race_armed", state_o, 2);
    key(4'h0); key(4'h9); key(4'h6);
    breach = 1'b1;
    key(4'h5);
    breach = 1'b0;
    chk("race_breach", state_o, 0);

    // Duress code from ARMED
    code(16'h0965);
    tick(16);
    chk("duress_armed", state_o, 2);
    code(16'h0964);
`ifdef DURESS_EN
    chk("duress_state", state_o, 0);
    chk("duress_flag", duress_alert, 1);
`else
    chk("duress_state", state_o, 2);
    chk("duress_flag", duress_alert, 0);
    code(16'h0000);
    chk("duress_f2", lockout, 0);
    code(16'h0000);
    chk("duress_f3", lockout, 1);
`endif

    // Async reset mid-operation
    tick(2);
    rst = 1'b1;
    #2;
    chk("arst_state", state_o, 0);
    chk("arst_lock", lockout, 0);
    chk("arst_led", led, 0);
    chk("arst_duress", duress_alert, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Top-level security controller that sequences the keypad datapath. It consumes decoded key events, assembles and checks passcode entries, and runs the arm/disarm state machine, including exit delay, entry delay and alarm. A wrong-code lockout throttles brute-force entry. It sits between the keypad scanner/decoder (key_valid/key_code) and the indicator LED and authorities-alert outputs.

Parameters:
CODE_LEN, 4, digits per passcode entry (1..8)
PASSCODE, 16'h0965, expected key codes, digit 0 in bits [15:12] (matrix encoding {row,col}: "1865")
CLEAR_KEY, 4'hF, key code that discards a partial entry
EXIT_DELAY, 16, cycles in EXIT before ARMED (>=1)
ENTRY_DELAY, 16, cycles in ENTRY before ALARM (>=1)
MAX_FAILS, 3, consecutive wrong entries that trigger lockout (>=1)
LOCKOUT_CYCLES, 32, cycles key entry is ignored after lockout (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
key_valid  in  1  one-cycle pulse, key_code valid
key_code  in  4  decoded key {row[1:0],col[1:0]}
breach  in  1  level, any sensor tripped
state_o  out  3  0 DISARMED, 1 EXIT, 2 ARMED, 3 ENTRY, 4 ALARM
is_enabled  out  1  1 in EXIT/ARMED/ENTRY/ALARM
led  out  1  1 when is_enabled
alert_authorities  out  1  1 only in ALARM
lockout  out  1  1 while key entry is locked out
duress_alert  out  1  silent alarm (see Optional Feature)

Behaviour:
- Reset: state DISARMED; digit count 0; fail count 0; lockout timer 0; all outputs 0.
- All outputs are registered and reflect the state after each clock edge.
- Entry engine: a key_valid with lockout=0 and key_code != CLEAR_KEY stores the digit and increments the count. CLEAR_KEY clears the count without counting a failure. key_valid while lockout=1 is ignored entirely, with no digit stored.
- On the edge accepting digit CODE_LEN, compare all CODE_LEN digits, including the incoming one, against PASSCODE, then zero the count.
  - Match: code_ok for that edge and fail count cleared.
  - Mismatch: fail count increments.
- Lockout: when fail count reaches MAX_FAILS, on that same edge set lockout=1, load the timer with LOCKOUT_CYCLES, and clear the fail count. lockout drops after exactly LOCKOUT_CYCLES cycles. Lockout does not affect the state machine or its timers.
- State transitions act on the same edge as code_ok (zero added latency).
- DISARMED: code_ok -> EXIT. breach is ignored.
- EXIT: code_ok -> DISARMED. After EXIT_DELAY cycles in EXIT -> ARMED. breach is ignored.
- ARMED: code_ok -> DISARMED. breach=1 -> ENTRY.
- ENTRY: code_ok -> DISARMED. After ENTRY_DELAY cycles in ENTRY -> ALARM. breach deassertion does not cancel ENTRY.
- ALARM: held until code_ok -> DISARMED, which clears alert_authorities on the same edge.
- Delay timer: loaded with DELAY-1 on entry to EXIT/ENTRY and decremented each cycle. It transitions when it is 0, so the state lasts exactly DELAY cycles.
- Simultaneous events:
  - code_ok beats timer expiry.
  - code_ok beats breach in ARMED, giving DISARMED.
  - CLEAR_KEY never counts as a failure.
- Reset mid-entry or mid-delay returns everything to reset values immediately.

Optional Feature:
DURESS_EN
- Defined: a second code is recognised, equal to PASSCODE with the last digit XOR 4'h1. It acts exactly as code_ok, clears the fail count, and additionally sets duress_alert=1. duress_alert stays set until rst.
- Undefined: the duress code is treated as a normal mismatch, and duress_alert is tied to 0.

Test Plan:
- Reset, then keys 0,9,6,5 -> state_o 0->1 on the 4th key edge; ARMED (2) exactly 16 cycles later; led=is_enabled=1.
- ARMED, breach pulse 1 cycle, no code -> ENTRY 16 cycles, then ALARM with alert_authorities=1. Keys 0,9,6,5 -> DISARMED; alert, led and is_enabled all 0.
- DISARMED, 3 wrong entries (0,0,0,0) -> lockout=1 for 32 cycles. During lockout, keys 0,9,6,5 have no effect (state stays 0). After lockout, the correct code arms.
- Keys 0,9 then CLEAR_KEY, then 0,9,6,5 -> arms. The fail count stays 0, checked by 2 further wrong codes producing no lockout.
- EXIT with the correct 4th digit on the cycle the timer hits 0 -> DISARMED, not ARMED. ARMED with breach and the 4th correct digit on the same edge -> DISARMED.
- With DURESS_EN: ARMED, keys 0,9,6,4 -> DISARMED and duress_alert=1. Without it: no state change, fail count 1.
